// File: rtl/pl_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
package pl_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [4:0] REG_X0             = 5'd0;
    localparam int         TIMEOUT_CYCLES_DEF = 64;

endpackage

// File: rtl/pl_hazard_detect.sv
// Load-use hazard compare between the load in EX and the source registers in ID.
module pl_hazard_detect
    import pl_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] idex_rd,
    input  logic       idex_mem_read,
    output logic       load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = id_use_rs1 && (id_rs1 == idex_rd);
    assign rs2_hit  = id_use_rs2 && (id_rs2 == idex_rd);
    // x0 is hardwired to zero, so a load targeting it never produces a dependency.
    assign load_use = idex_mem_read && (idex_rd != REG_X0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pl_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline with a data-memory wait FSM.
// Optional performance counters are built when STALL_PERF_EN is defined.
module pl_stall_ctrl
    import pl_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int CNT_W          = 7,
    parameter int PERF_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [4:0]        idex_rd,
    input  logic              idex_mem_read,
    input  logic              ex_redirect,
    input  logic              mem_op_valid,
    input  logic              dmem_ready,
    output logic              dmem_req,
    output logic              stall_pc,
    output logic              stall_ifid,
    output logic              stall_idex,
    output logic              stall_exmem,
    output logic              stall_memwb,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic              mem_err,
    output logic [PERF_W-1:0] perf_load_use,
    output logic [PERF_W-1:0] perf_mem_wait,
    output logic [PERF_W-1:0] perf_flush
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_nxt;

    logic load_use;
    logic mem_busy;
    logic mem_stall;
    logic mem_timeout;
    logic redirect_flush;
    logic lu_stall;

    pl_hazard_detect u_hazard (
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_use_rs1    (id_use_rs1),
        .id_use_rs2    (id_use_rs2),
        .idex_rd       (idex_rd),
        .idex_mem_read (idex_mem_read),
        .load_use      (load_use)
    );

    assign mem_busy = mem_op_valid && !dmem_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        mem_stall    = 1'b0;
        mem_timeout  = 1'b0;
        case (state)
            RUN: begin
                if (mem_busy) begin
                    mem_stall    = 1'b1;
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = CNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES)) begin
                    // Abandon the access: release the pipeline and let MEM/WB take what it has.
                    mem_timeout  = 1'b1;
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else begin
                    mem_stall    = 1'b1;
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    // A memory wait freezes EX, so redirect/load-use act only once it releases;
    // a redirect makes the ID instruction wrong-path, so it overrides load-use.
    assign redirect_flush = ex_redirect && !mem_stall;
    assign lu_stall       = load_use && !mem_stall && !ex_redirect;

    assign dmem_req    = rst && mem_op_valid;
    assign stall_pc    = rst && (mem_stall || lu_stall);
    assign stall_ifid  = rst && (mem_stall || lu_stall);
    assign stall_idex  = rst && mem_stall;
    assign stall_exmem = rst && mem_stall;
    assign stall_memwb = rst && mem_stall;
    assign flush_ifid  = rst && redirect_flush;
    assign flush_idex  = rst && (redirect_flush || lu_stall);
    assign mem_err     = rst && mem_timeout;

`ifdef STALL_PERF_EN
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v, input logic en);
        return (en && !(&v)) ? v + PERF_W'(1) : v;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_load_use <= '0;
            perf_mem_wait <= '0;
            perf_flush    <= '0;
        end else begin
            perf_load_use <= sat_inc(perf_load_use, lu_stall);
            perf_mem_wait <= sat_inc(perf_mem_wait, mem_stall);
            perf_flush    <= sat_inc(perf_flush, redirect_flush);
        end
    end
`else
    assign perf_load_use = '0;
    assign perf_mem_wait = '0;
    assign perf_flush    = '0;
`endif

endmodule

// File: tb/tb_pl_stall_ctrl.sv
// Directed bench for pl_stall_ctrl: vector table plus multi-cycle wait/timeout/reset sequences.
module tb_pl_stall_ctrl;

    localparam int PERF_W = 32;
`ifdef STALL_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    // Output bundle order: {req, spc, sif, sid, sex, smw, fif, fid, err}
    localparam logic [8:0] E_NONE  = 9'b000000000;
    localparam logic [8:0] E_LU    = 9'b011000010;
    localparam logic [8:0] E_REDIR = 9'b000000110;
    localparam logic [8:0] E_REQ   = 9'b100000000;
    localparam logic [8:0] E_MEMST = 9'b111111000;
    localparam logic [8:0] E_REQRD = 9'b100000110;
    localparam logic [8:0] E_ERR   = 9'b100000001;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] id_rs1, id_rs2, idex_rd;
    logic id_use_rs1, id_use_rs2, idex_mem_read, ex_redirect, mem_op_valid, dmem_ready;
    logic dmem_req, stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb;
    logic flush_ifid, flush_idex, mem_err;
    logic [PERF_W-1:0] perf_load_use, perf_mem_wait, perf_flush;

    always #5 clk = ~clk;

    pl_stall_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(7), .PERF_W(PERF_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_use_rs1    (id_use_rs1),
        .id_use_rs2    (id_use_rs2),
        .idex_rd       (idex_rd),
        .idex_mem_read (idex_mem_read),
        .ex_redirect   (ex_redirect),
        .mem_op_valid  (mem_op_valid),
        .dmem_ready    (dmem_ready),
        .dmem_req      (dmem_req),
        .stall_pc      (stall_pc),
        .stall_ifid    (stall_ifid),
        .stall_idex    (stall_idex),
        .stall_exmem   (stall_exmem),
        .stall_memwb   (stall_memwb),
        .flush_ifid    (flush_ifid),
        .flush_idex    (flush_idex),
        .mem_err       (mem_err),
        .perf_load_use (perf_load_use),
        .perf_mem_wait (perf_mem_wait),
        .perf_flush    (perf_flush)
    );

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic [4:0] rd;
        logic       mr;
        logic       redir;
        logic       mov;
        logic       rdy;
        logic [8:0] exp;
    } vec_t;

    vec_t vt[17];
    int tests = 0;
    int fails = 0;

    function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic use1,
                                input logic use2, input logic [4:0] rd, input logic mr,
                                input logic redir, input logic mov, input logic rdy,
                                input logic [8:0] exp);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.use1 = use1; v.use2 = use2; v.rd = rd;
        v.mr = mr; v.redir = redir; v.mov = mov; v.rdy = rdy; v.exp = exp;
        return v;
    endfunction

    function automatic logic [8:0] outs();
        return {dmem_req, stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb,
                flush_ifid, flush_idex, mem_err};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.use1; id_use_rs2 = v.use2;
        idex_rd = v.rd; idex_mem_read = v.mr; ex_redirect = v.redir;
        mem_op_valid = v.mov; dmem_ready = v.rdy;
    endtask

    task automatic idle();
        apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE));
    endtask

    task automatic mem(input logic mov, input logic rdy);
        idle();
        mem_op_valid = mov;
        dmem_ready   = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input string nm, input logic [8:0] exp);
        @(negedge clk);
        chk(nm, 32'(outs()), 32'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, E_NONE);
        vt[1]  = mk(5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 0, 0, E_LU);
        vt[2]  = mk(5'd5, 5'd0, 1, 0, 5'd0, 0, 0, 0, 0, E_NONE);
        vt[3]  = mk(5'd0, 5'd0, 1, 0, 5'd0, 1, 0, 0, 0, E_NONE);
        vt[4]  = mk(5'd0, 5'd7, 0, 1, 5'd7, 1, 0, 0, 0, E_LU);
        vt[5]  = mk(5'd0, 5'd7, 0, 0, 5'd7, 1, 0, 0, 0, E_NONE);
        vt[6]  = mk(5'd5, 5'd0, 1, 0, 5'd5, 0, 0, 0, 0, E_NONE);
        vt[7]  = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, E_REDIR);
        vt[8]  = mk(5'd9, 5'd0, 1, 0, 5'd9, 1, 1, 0, 0, E_REDIR);
        vt[9]  = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, E_REQ);
        vt[10] = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, E_MEMST);
        vt[11] = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 0, E_MEMST);
        vt[12] = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 1, E_REQRD);
        vt[13] = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, E_NONE);
        vt[14] = mk(5'd3, 5'd0, 1, 0, 5'd3, 1, 0, 1, 0, E_MEMST);
        vt[15] = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, E_REQ);
        vt[16] = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, E_NONE);

        // Reset held with inputs that would otherwise assert outputs
        mem(1'b1, 1'b0);
        ex_redirect = 1'b1;
        rst = 1'b0;
        repeat (2) step();
        chk("reset_outs", 32'(outs()), 32'(E_NONE));
        chk("reset_perf_lu", perf_load_use, 32'd0);
        chk("reset_perf_mw", perf_mem_wait, 32'd0);
        chk("reset_perf_fl", perf_flush, 32'd0);
        idle();
        rst = 1'b1;
        step();

        for (int i = 0; i < 17; i++) begin
            apply(vt[i]);
            sample($sformatf("vec%0d", i), vt[i].exp);
            step();
        end
        idle();
        chk("tbl_perf_lu", perf_load_use, PERF_ON ? 32'd2 : 32'd0);
        chk("tbl_perf_mw", perf_mem_wait, PERF_ON ? 32'd3 : 32'd0);
        chk("tbl_perf_fl", perf_flush, PERF_ON ? 32'd3 : 32'd0);

        // Three-cycle memory wait, released on the ready cycle
        for (int i = 0; i < 3; i++) begin
            mem(1'b1, 1'b0);
            sample($sformatf("wait3_c%0d", i), E_MEMST);
            step();
        end
        mem(1'b1, 1'b1);
        sample("wait3_ready", E_REQ);
        step();
        idle();
        sample("wait3_run", E_NONE);
        chk("wait3_perf_mw", perf_mem_wait, PERF_ON ? 32'd6 : 32'd0);
        step();

        // Timeout: four stalled cycles, error pulse with release on the fifth
        for (int i = 0; i < 4; i++) begin
            mem(1'b1, 1'b0);
            sample($sformatf("tmo_c%0d", i), E_MEMST);
            step();
        end
        mem(1'b1, 1'b0);
        sample("tmo_err", E_ERR);
        step();
        idle();
        sample("tmo_run", E_NONE);
        chk("tmo_perf_mw", perf_mem_wait, PERF_ON ? 32'd10 : 32'd0);
        step();
        mem(1'b1, 1'b1);
        sample("tmo_single", E_REQ);
        step();

        // Reset asserted mid-wait
        mem(1'b1, 1'b0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rstmid_outs", 32'(outs()), 32'(E_NONE));
        step();
        chk("rstmid_hold", 32'(outs()), 32'(E_NONE));
        idle();
        rst = 1'b1;
        sample("rstmid_run", E_NONE);
        chk("rstmid_perf_lu", perf_load_use, 32'd0);
        chk("rstmid_perf_mw", perf_mem_wait, 32'd0);
        chk("rstmid_perf_fl", perf_flush, 32'd0);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pl_stall_ctrl.md
Name: pl_stall_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline: PC, IF/ID, ID/EX, EX/MEM, MEM/WB.
- Detects load-use hazards and EX-stage control redirects.
- Runs a variable-latency data-memory handshake FSM.
- Drives every pipeline register's stall and flush inputs.

Parameters:
- TIMEOUT_CYCLES, 64: max cycles in MEM_WAIT before the access is abandoned.
- CNT_W, 7: wait-counter width; must hold TIMEOUT_CYCLES.
- PERF_W, 32: width of the performance counters (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- id_rs1  in  5  rs1 of the instruction in ID
- id_rs2  in  5  rs2 of the instruction in ID
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- idex_rd  in  5  rd of the instruction in EX
- idex_mem_read  in  1  instruction in EX is a load
- ex_redirect  in  1  EX resolved a taken branch/jump
- mem_op_valid  in  1  EX/MEM holds a load or store
- dmem_ready  in  1  data memory completes the access this cycle
- dmem_req  out  1  request to data memory
- stall_pc  out  1  hold PC
- stall_ifid  out  1  hold IF/ID
- stall_idex  out  1  hold ID/EX
- stall_exmem  out  1  hold EX/MEM
- stall_memwb  out  1  hold MEM/WB
- flush_ifid  out  1  clear IF/ID next edge
- flush_idex  out  1  clear ID/EX next edge
- mem_err  out  1  one-cycle pulse on timeout
- perf_load_use  out  PERF_W  load-use stall cycles
- perf_mem_wait  out  PERF_W  memory-wait stall cycles
- perf_flush  out  PERF_W  redirect flushes

Behaviour:
- FSM states: RUN, MEM_WAIT. wait_cnt is CNT_W bits.
- Reset (rst low, async): state=RUN, wait_cnt=0, perf counters=0. All outputs forced 0 while rst is low.
- Stall, flush and dmem_req outputs are combinational from state and inputs; zero added latency.
- mem_busy = mem_op_valid && !dmem_ready, in either state.
- dmem_req = mem_op_valid.
- RUN, mem_busy: stall all five stage outputs plus PC; next state MEM_WAIT; wait_cnt <= 1.
- RUN, mem_op_valid && dmem_ready: single-cycle access; no stall; stay in RUN.
- MEM_WAIT, !dmem_ready: all stalls held; wait_cnt++.
- MEM_WAIT, dmem_ready: stalls deasserted that same cycle so the pipeline advances; next state RUN; wait_cnt <= 0.
- MEM_WAIT, wait_cnt == TIMEOUT_CYCLES with !dmem_ready:
  - mem_err pulses one cycle and stalls are released.
  - Next state RUN; the access is dropped (MEM/WB latches whatever read data is present).
- Load-use: idex_mem_read && idex_rd!=0 && ((id_use_rs1 && id_rs1==idex_rd) || (id_use_rs2 && id_rs2==idex_rd)).
  - Response: stall_pc=1, stall_ifid=1, flush_idex=1 (one bubble).
  - Held for exactly one cycle per instance, since the load advances.
- Redirect: ex_redirect -> flush_ifid=1, flush_idex=1; no stalls.
- Priority: memory wait > redirect > load-use.
  - While memory stall is active, flush_* = 0. A pending redirect in EX is frozen with EX and takes effect on the release cycle.
  - Redirect with load-use in the same cycle: flush wins; no PC/IF/ID stall (the ID instruction is wrong-path).
- rd=x0 never causes a load-use stall.
- Reset asserted mid-MEM_WAIT: immediate return to RUN, dmem_req=0. No mem_err.

Optional Feature:
- Macro STALL_PERF_EN.
- When defined:
  - perf_load_use increments each cycle a load-use stall is applied.
  - perf_mem_wait increments each cycle memory stalls are applied.
  - perf_flush increments each cycle ex_redirect flushes.
  - All three saturate at all-ones and reset to 0.
- When undefined: perf_* ports are present but tied to 0; no counter flops.

Decomposition:
- Shared package pl_ctrl_pkg:
  - state encoding: RUN=1'b0, MEM_WAIT=1'b1
  - REG_X0 = 5'd0
  - default TIMEOUT_CYCLES constant
- One combinational sub-module, pl_hazard_detect: load-use compare producing load_use. Instantiated once inside pl_stall_ctrl.

Test Plan:
- Load x5 in EX (idex_mem_read=1, idex_rd=5), ID reads rs1=5, use_rs1=1 -> stall_pc=stall_ifid=flush_idex=1 for one cycle; zero the next cycle. Same case with rd=0 -> no stall.
- mem_op_valid=1, dmem_ready low 3 cycles then high -> all stalls high for 3 cycles, low on the ready cycle; state back to RUN; perf_mem_wait=3 (STALL_PERF_EN).
- mem_op_valid=1, dmem_ready=1 the same cycle -> dmem_req=1, no stalls, state stays RUN.
- ex_redirect=1 during a 2-cycle memory wait -> flush_ifid/flush_idex stay 0 during the wait, assert on the release cycle.
- dmem_ready held low with TIMEOUT_CYCLES=4 -> mem_err single pulse at the 4th wait cycle; stalls released; RUN next cycle.
- rst pulled low while in MEM_WAIT -> all outputs 0 immediately; after release, state RUN and perf counters 0.
